// File: rtl/mac_ll_pkg.sv
// Shared LocalLink definitions for the MAC transmit path.
// Holds flag bit positions, the word width and the tx arbiter state encoding.
// No ports; imported with import mac_ll_pkg::*.
package mac_ll_pkg;

  localparam int LL_DATA_W = 32;
  localparam int LL_FLAG_W = 4;

  // Flag word layout: SOF, EOF, then a 2-bit occupancy field carried through untouched.
  localparam int FLAG_SOF    = 0;
  localparam int FLAG_EOF    = 1;
  localparam int FLAG_OCC_LO = 2;
  localparam int FLAG_OCC_HI = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_GRANT0 = 4'd1,
    ST_GRANT1 = 4'd2,
    ST_FLUSH0 = 4'd3,
    ST_FLUSH1 = 4'd4
  } arb_state_e;

endpackage

// File: rtl/ll_rr_pick.sv
// Two-input round-robin picker: one-hot grant from candidate mask and last winner.
// Latency: purely combinational.
// Backpressure: none; the caller registers the grant.
// Ports: cand_i (bit n = requester n wants a grant), last_grant_i (index of the
//        previous winner), grant_o (one-hot, zero when no candidate).
module ll_rr_pick (
  input  logic [1:0] cand_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (cand_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: the requester that did not win last time goes first.
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular arbiter sharing the MAC TX FIFO write port between two LocalLink sources.
// Latency: 1 cycle SOF-to-grant, then a combinational data mux from the granted requester.
// Backpressure: wr_dst_rdy_i passes straight to the granted requester; the other is held off.
// Ports: clk/reset (async, active-high); req0_*/req1_* LocalLink inputs with
//        reqN_dst_rdy_o; wr_* LocalLink output to the FIFO; busy_o; pkt_count_o
//        (EOF transfers); drop_count_o (stray and flushed words).
// Optional MAC_TX_ARB_WATCHDOG_EN: a grant whose source stalls for TIMEOUT cycles is
//        terminated with a forced EOF word and the rest of that packet is flushed.
module mac_tx_arbiter
  import mac_ll_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LL_FLAG_W-1:0] req0_flags_i,
  input  logic [LL_DATA_W-1:0] req0_data_i,
  input  logic                 req0_src_rdy_i,
  output logic                 req0_dst_rdy_o,
  input  logic [LL_FLAG_W-1:0] req1_flags_i,
  input  logic [LL_DATA_W-1:0] req1_data_i,
  input  logic                 req1_src_rdy_i,
  output logic                 req1_dst_rdy_o,
  output logic [LL_FLAG_W-1:0] wr_flags_o,
  output logic [LL_DATA_W-1:0] wr_data_o,
  output logic                 wr_src_rdy_o,
  input  logic                 wr_dst_rdy_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     pkt_count_o,
  output logic [CNT_W-1:0]     drop_count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("mac_tx_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [1:0] cand, grant;
  logic       idle, g0, g1, fl0, fl1;
  logic       stray0, stray1, flush0, flush1;
  logic       xfer, xfer_eof, force_eof;

  assign idle = (state_q == ST_IDLE);
  assign g0   = (state_q == ST_GRANT0);
  assign g1   = (state_q == ST_GRANT1);

`ifdef MAC_TX_ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               force_q, force_d;
  logic               stalled;

  assign force_eof = force_q;
  assign fl0       = (state_q == ST_FLUSH0);
  assign fl1       = (state_q == ST_FLUSH1);
`else
  assign force_eof = 1'b0;
  assign fl0       = 1'b0;
  assign fl1       = 1'b0;
`endif

  // Mid-packet words arriving while idle have no owner; swallow them. Gated by
  // reset so every output reads 0 while reset is held.
  assign stray0 = idle & req0_src_rdy_i & ~req0_flags_i[FLAG_SOF] & ~reset;
  assign stray1 = idle & req1_src_rdy_i & ~req1_flags_i[FLAG_SOF] & ~reset;
  assign flush0 = fl0 & req0_src_rdy_i;
  assign flush1 = fl1 & req1_src_rdy_i;

  assign cand = {req1_src_rdy_i & req1_flags_i[FLAG_SOF],
                 req0_src_rdy_i & req0_flags_i[FLAG_SOF]};

  ll_rr_pick u_pick (
    .cand_i       (cand),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  always_comb begin
    wr_src_rdy_o = 1'b0;
    wr_flags_o   = '0;
    wr_data_o    = '0;
    if (force_eof) begin
      wr_src_rdy_o = 1'b1;
      wr_flags_o   = 4'b0010;
    end else if (g0) begin
      wr_src_rdy_o = req0_src_rdy_i;
      wr_flags_o   = req0_flags_i;
      wr_data_o    = req0_data_i;
    end else if (g1) begin
      wr_src_rdy_o = req1_src_rdy_i;
      wr_flags_o   = req1_flags_i;
      wr_data_o    = req1_data_i;
    end
  end

  assign req0_dst_rdy_o = (g0 & ~force_eof & wr_dst_rdy_i & req0_src_rdy_i) | stray0 | flush0;
  assign req1_dst_rdy_o = (g1 & ~force_eof & wr_dst_rdy_i & req1_src_rdy_i) | stray1 | flush1;

  assign xfer     = wr_src_rdy_o & wr_dst_rdy_i & ~force_eof;
  assign xfer_eof = xfer & wr_flags_o[FLAG_EOF];
  assign busy_o   = ~idle;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    drop_d  = drop_q + CNT_W'(stray0) + CNT_W'(stray1) + CNT_W'(flush0) + CNT_W'(flush1);
    case (state_q)
      ST_IDLE: begin
        if (grant[0])      state_d = ST_GRANT0;
        else if (grant[1]) state_d = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (xfer_eof) begin
          state_d = ST_IDLE;
          last_d  = g1;
          pkt_d   = pkt_q + CNT_ONE;
        end
`ifdef MAC_TX_ARB_WATCHDOG_EN
        // The forced EOF closes the frame at the MAC, so it counts as a packet.
        if (force_q && wr_dst_rdy_i) begin
          state_d = g0 ? ST_FLUSH0 : ST_FLUSH1;
          last_d  = g1;
          pkt_d   = pkt_q + CNT_ONE;
        end
`endif
      end
`ifdef MAC_TX_ARB_WATCHDOG_EN
      ST_FLUSH0: if (flush0 && req0_flags_i[FLAG_EOF]) state_d = ST_IDLE;
      ST_FLUSH1: if (flush1 && req1_flags_i[FLAG_EOF]) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MAC_TX_ARB_WATCHDOG_EN
  // Only source-side starvation counts; a MAC that deasserts ready is never blamed.
  always_comb begin
    stall_d = stall_q;
    force_d = force_q;
    stalled = 1'b0;
    if (g0 || g1) begin
      stalled = ~force_q & ((g0 & ~req0_src_rdy_i) | (g1 & ~req1_src_rdy_i));
      if (xfer) begin
        stall_d = '0;
      end else if (stalled) begin
        if (stall_q == STALL_W'(TIMEOUT - 1)) force_d = 1'b1;
        else                                  stall_d = stall_q + 1'b1;
      end
      if (force_q && wr_dst_rdy_i) begin
        force_d = 1'b0;
        stall_d = '0;
      end
    end else begin
      stall_d = '0;
      force_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      force_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      force_q <= force_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
    end
  end

  assign pkt_count_o  = pkt_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: arbitration, hold-off, backpressure,
// stray-word drops, async reset and (when built with the watchdog) forced EOF.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_mac_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req0_flags, req1_flags, wr_flags;
  logic [31:0] req0_data, req1_data, wr_data;
  logic        req0_src, req1_src, req0_dst, req1_dst;
  logic        wr_src, wr_dst, busy;
  logic [15:0] pkt_cnt, drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mac_tx_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0_flags_i   (req0_flags),
    .req0_data_i    (req0_data),
    .req0_src_rdy_i (req0_src),
    .req0_dst_rdy_o (req0_dst),
    .req1_flags_i   (req1_flags),
    .req1_data_i    (req1_data),
    .req1_src_rdy_i (req1_src),
    .req1_dst_rdy_o (req1_dst),
    .wr_flags_o     (wr_flags),
    .wr_data_o      (wr_data),
    .wr_src_rdy_o   (wr_src),
    .wr_dst_rdy_i   (wr_dst),
    .busy_o         (busy),
    .pkt_count_o    (pkt_cnt),
    .drop_count_o   (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish, still running at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic src, input logic [3:0] fl, input logic [31:0] d);
    req0_src = src; req0_flags = fl; req0_data = d;
  endtask

  task automatic drv1(input logic src, input logic [3:0] fl, input logic [31:0] d);
    req1_src = src; req1_flags = fl; req1_data = d;
  endtask

  initial begin
    reset  = 1'b1;
    wr_dst = 1'b1;
    drv1(1'b0, 4'h0, 32'h0);
    // A stray word during reset must not be acknowledged.
    drv0(1'b1, 4'b0000, 32'hDEADBEEF);
    #1;
    chk("rst_dst0",   32'(req0_dst), 32'd0);
    chk("rst_wr_src", 32'(wr_src),   32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_pkt",    32'(pkt_cnt),  32'd0);
    chk("rst_drop",   32'(drop_cnt), 32'd0);
    chk("rst_data",   wr_data,       32'd0);
    drv0(1'b0, 4'h0, 32'h0);
    step; step;
    reset = 1'b0;
    #1;

    // Simultaneous SOF after reset: req0 first, req1 right after req0's EOF.
    drv0(1'b1, 4'b0011, 32'h0000_00B0);
    drv1(1'b1, 4'b0001, 32'h0000_00C0);
    #1;
    chk("t2_idle_src",  32'(wr_src),   32'd0);
    chk("t2_idle_dst0", 32'(req0_dst), 32'd0);
    step;
    chk("t2_g0_data", wr_data,        32'h0000_00B0);
    chk("t2_g0_dst0", 32'(req0_dst),  32'd1);
    chk("t2_g0_dst1", 32'(req1_dst),  32'd0);
    step;
    drv0(1'b0, 4'h0, 32'h0);
    #1;
    chk("t2_idle2_src", 32'(wr_src),   32'd0);
    chk("t2_pkt1",      32'(pkt_cnt),  32'd1);
    chk("t2_idle2_dst1", 32'(req1_dst), 32'd0);
    step;
    chk("t2_g1_data", wr_data,       32'h0000_00C0);
    chk("t2_g1_dst1", 32'(req1_dst), 32'd1);
    step;
    drv1(1'b1, 4'b0010, 32'h0000_00C1);
    #1;
    chk("t2_eof_flags", 32'(wr_flags), 32'h2);
    step;
    drv1(1'b0, 4'h0, 32'h0);
    #1;
    chk("t2_pkt2", 32'(pkt_cnt), 32'd2);
    chk("t2_busy", 32'(busy),    32'd0);

    // Req0 3-word packet, MAC always ready.
    drv0(1'b1, 4'b0001, 32'h0000_00A0);
    #1;
    chk("t1_latency", 32'(wr_src), 32'd0);
    step;
    chk("t1_w0_data",  wr_data,        32'h0000_00A0);
    chk("t1_w0_flags", 32'(wr_flags),  32'h1);
    chk("t1_busy",     32'(busy),      32'd1);
    step;
    drv0(1'b1, 4'b0000, 32'h0000_00A1);
    #1;
    chk("t1_w1_data", wr_data,       32'h0000_00A1);
    chk("t1_dst1",    32'(req1_dst), 32'd0);
    step;
    drv0(1'b1, 4'b0010, 32'h0000_00A2);
    #1;
    chk("t1_w2_data", wr_data, 32'h0000_00A2);
    step;
    drv0(1'b0, 4'h0, 32'h0);
    #1;
    chk("t1_pkt",    32'(pkt_cnt), 32'd3);
    chk("t1_wr_src", 32'(wr_src),  32'd0);

    // Req1 SOF while req0 is mid-packet, MAC ready toggling.
    drv0(1'b1, 4'b0001, 32'h0000_00D0);
    #1;
    step;
    drv1(1'b1, 4'b0001, 32'h0000_00E0);
    wr_dst = 1'b0;
    #1;
    chk("t3_stall_src",  32'(wr_src),   32'd1);
    chk("t3_stall_dst0", 32'(req0_dst), 32'd0);
    chk("t3_hold1",      32'(req1_dst), 32'd0);
    step;
    wr_dst = 1'b1;
    #1;
    chk("t3_d0", wr_data, 32'h0000_00D0);
    step;
    drv0(1'b1, 4'b0000, 32'h0000_00D1);
    wr_dst = 1'b0;
    #1;
    chk("t3_d1_wait", wr_data,       32'h0000_00D1);
    chk("t3_d1_dst0", 32'(req0_dst), 32'd0);
    step;
    wr_dst = 1'b1;
    #1;
    chk("t3_d1",       wr_data,       32'h0000_00D1);
    chk("t3_d1_dst1",  32'(req1_dst), 32'd0);
    step;
    drv0(1'b1, 4'b0010, 32'h0000_00D2);
    wr_dst = 1'b0;
    #1;
    step;
    wr_dst = 1'b1;
    #1;
    chk("t3_d2", wr_data, 32'h0000_00D2);
    step;
    drv0(1'b0, 4'h0, 32'h0);
    #1;
    chk("t3_pkt",      32'(pkt_cnt), 32'd4);
    chk("t3_idle_src", 32'(wr_src),  32'd0);
    step;
    chk("t3_e0", wr_data, 32'h0000_00E0);
    step;
    drv1(1'b1, 4'b0010, 32'h0000_00E1);
    #1;
    step;
    drv1(1'b0, 4'h0, 32'h0);
    #1;
    chk("t3_pkt2", 32'(pkt_cnt), 32'd5);

    // Stray non-SOF words in IDLE are consumed and counted.
    drv0(1'b1, 4'b0000, 32'hDEADBEEF);
    #1;
    chk("t4_dst0", 32'(req0_dst), 32'd1);
    chk("t4_src",  32'(wr_src),   32'd0);
    step;
    drv0(1'b0, 4'h0, 32'h0);
    #1;
    chk("t4_drop1", 32'(drop_cnt), 32'd1);
    chk("t4_busy",  32'(busy),      32'd0);
    drv0(1'b1, 4'b0000, 32'h1);
    drv1(1'b1, 4'b0100, 32'h2);
    #1;
    chk("t4_dst1", 32'(req1_dst), 32'd1);
    step;
    drv0(1'b0, 4'h0, 32'h0);
    drv1(1'b0, 4'h0, 32'h0);
    #1;
    chk("t4_drop3", 32'(drop_cnt), 32'd3);

    // Async reset mid-packet in GRANT1.
    drv1(1'b1, 4'b0001, 32'h0000_00F0);
    #1;
    step;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_data", wr_data,   32'h0000_00F0);
    reset = 1'b1;
    #1;
    chk("t6_rst_src",  32'(wr_src),   32'd0);
    chk("t6_rst_busy", 32'(busy),     32'd0);
    chk("t6_rst_dst1", 32'(req1_dst), 32'd0);
    chk("t6_rst_pkt",  32'(pkt_cnt),  32'd0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
    step;
    drv0(1'b1, 4'b0011, 32'h0000_0060);
    drv1(1'b1, 4'b0001, 32'h0000_00F0);
    reset = 1'b0;
    #1;
    step;
    chk("t6_g0_data", wr_data,       32'h0000_0060);
    chk("t6_g0_dst1", 32'(req1_dst), 32'd0);
    step;
    drv0(1'b0, 4'h0, 32'h0);
    drv1(1'b0, 4'h0, 32'h0);
    #1;
    chk("t6_pkt", 32'(pkt_cnt), 32'd1);

`ifdef MAC_TX_ARB_WATCHDOG_EN
    // SOF, then 8 idle cycles -> forced EOF, remaining 2 words flushed.
    drv0(1'b1, 4'b0001, 32'h0000_0070);
    #1;
    step;
    step;
    drv0(1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 7; i++) step;
    chk("wd_not_yet", 32'(wr_src), 32'd0);
    step;
    chk("wd_src",   32'(wr_src),   32'd1);
    chk("wd_flags", 32'(wr_flags), 32'h2);
    chk("wd_data",  wr_data,       32'd0);
    step;
    drv0(1'b1, 4'b0000, 32'h0000_0071);
    #1;
    chk("wd_fl_dst0", 32'(req0_dst), 32'd1);
    chk("wd_fl_src",  32'(wr_src),   32'd0);
    step;
    drv0(1'b1, 4'b0010, 32'h0000_0072);
    #1;
    step;
    drv0(1'b0, 4'h0, 32'h0);
    #1;
    chk("wd_drop", 32'(drop_cnt), 32'd2);
    chk("wd_idle", 32'(busy),     32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
